// File: rtl/aud_recorder.sv
// aud_recorder: captures left-channel 16-bit I2S ADC samples and writes them
// to sequential SRAM word addresses using a valid/ready handshake.
// Optional build macro AUD_RECORDER_DROP_CNT_EN enables the saturating
// dropped-sample counter; without it o_drop_cnt is tied to zero.
//
// state   | meaning
// IDLE    | not recording, no writes issued
// RUN     | capture sub-FSM active, words written as they complete
// PAUSED  | capture halted at a word boundary, address kept
//
// cap     | meaning
// WAIT_L  | waiting for LRCK falling edge (start of left word)
// SKIP    | discarding the I2S one-bit delay slot
// SHIFT   | sampling 16 data bits MSB first
module aud_recorder #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 20
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_AUD_BCLK,
    input  logic              i_AUD_ADCLRCK,
    input  logic              i_AUD_ADCDAT,
    input  logic [ADDR_W-1:0] i_addr_max,
    output logic [15:0]       o_data,
    output logic [ADDR_W-1:0] o_address,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_busy,
    output logic              o_paused,
    output logic              o_full,
    output logic [ADDR_W-1:0] o_end_addr,
    output logic [7:0]        o_drop_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;
    typedef enum logic [1:0] {WAIT_L, SKIP, SHIFT} cap_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t state, state_nxt;
    cap_t   cap, cap_nxt;
    logic   pause_pend, pause_nxt;

    logic [SYNC_STAGES-1:0] sync_bclk, sync_lrck, sync_dat;
    logic bclk_q, lrck_q;
    logic bclk_s, lrck_s, dat_s;
    logic bclk_rise, lrck_fall;

    logic [3:0]        bit_cnt;
    logic [15:0]       shreg;
    logic [15:0]       word;
    logic [ADDR_W-1:0] last_acc;

    logic accept, full_hit, word_done, load, start_idle;

    assign bclk_s    = sync_bclk[SYNC_STAGES-1];
    assign lrck_s    = sync_lrck[SYNC_STAGES-1];
    assign dat_s     = sync_dat[SYNC_STAGES-1];
    assign bclk_rise = bclk_s & ~bclk_q;
    assign lrck_fall = lrck_q & ~lrck_s;
    assign word      = {shreg[14:0], dat_s};

    assign o_busy   = (state != IDLE);
    assign o_paused = (state == PAUSED);

    // Synchronize the asynchronous codec pins and keep one-cycle history for edges.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_bclk <= '0;
            sync_lrck <= '0;
            sync_dat  <= '0;
            bclk_q    <= 1'b0;
            lrck_q    <= 1'b0;
        end else begin
            sync_bclk[0] <= i_AUD_BCLK;
            sync_lrck[0] <= i_AUD_ADCLRCK;
            sync_dat[0]  <= i_AUD_ADCDAT;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_bclk[i] <= sync_bclk[i-1];
                sync_lrck[i] <= sync_lrck[i-1];
                sync_dat[i]  <= sync_dat[i-1];
            end
            bclk_q <= bclk_s;
            lrck_q <= lrck_s;
        end
    end

    // State registers for the control and capture FSMs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            cap        <= WAIT_L;
            pause_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            cap        <= cap_nxt;
            pause_pend <= pause_nxt;
        end
    end

    // Next-state logic with stop > full > pause > start priority.
    always_comb begin
        state_nxt  = state;
        cap_nxt    = cap;
        pause_nxt  = pause_pend;
        start_idle = 1'b0;
        accept     = o_valid & i_ready;
        full_hit   = accept && (o_address == i_addr_max);
        word_done  = (state == RUN) && (cap == SHIFT) && bclk_rise && (bit_cnt == 4'd15);
        load       = word_done && !i_stop && !full_hit && (!o_valid || i_ready);
        if (i_stop || full_hit) begin
            state_nxt = IDLE;
            cap_nxt   = WAIT_L;
            pause_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state_nxt  = RUN;
                        cap_nxt    = WAIT_L;
                        start_idle = 1'b1;
                    end
                end
                RUN: begin
                    if ((i_pause || pause_pend) && cap == WAIT_L) begin
                        state_nxt = PAUSED;
                        pause_nxt = 1'b0;
                    end else begin
                        if (i_pause) pause_nxt = 1'b1;
                        case (cap)
                            WAIT_L:  if (lrck_fall) cap_nxt = SKIP;
                            SKIP:    if (bclk_rise) cap_nxt = SHIFT;
                            SHIFT:   if (word_done) cap_nxt = WAIT_L;
                            default: cap_nxt = WAIT_L;
                        endcase
                    end
                end
                PAUSED: begin
                    if (i_start) begin
                        state_nxt = RUN;
                        cap_nxt   = WAIT_L;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Serial-to-parallel shift register and bit counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (state == RUN && bclk_rise) begin
            if (cap == SKIP) begin
                bit_cnt <= '0;
            end else if (cap == SHIFT) begin
                shreg   <= word;
                bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

    // Write handshake, address sequencing, full detection and end address.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_data     <= '0;
            o_address  <= '0;
            o_valid    <= 1'b0;
            o_full     <= 1'b0;
            o_end_addr <= '0;
            last_acc   <= '0;
        end else if (i_stop) begin
            o_valid    <= 1'b0;
            o_end_addr <= last_acc;
        end else begin
            if (start_idle) begin
                o_full    <= 1'b0;
                o_address <= '0;
                last_acc  <= '0;
            end
            if (accept) begin
                o_valid  <= 1'b0;
                last_acc <= o_address;
                if (full_hit) begin
                    o_full     <= 1'b1;
                    o_end_addr <= o_address;
                end else begin
                    o_address <= o_address + ADDR_ONE;
                end
            end
            if (load) begin
                o_data  <= word;
                o_valid <= 1'b1;
            end
        end
    end

`ifdef AUD_RECORDER_DROP_CNT_EN
    logic [7:0] drop_cnt;
    logic       drop_evt;

    assign drop_evt   = word_done && !i_stop && o_valid && !i_ready;
    assign o_drop_cnt = drop_cnt;

    // Saturating count of words discarded because the previous one was still pending.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            drop_cnt <= '0;
        end else if (!i_stop && start_idle) begin
            drop_cnt <= '0;
        end else if (drop_evt && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`else
    assign o_drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_aud_recorder.sv
// Directed bench for aud_recorder: drives I2S frames with a slow BCLK and
// checks writes, addresses, pause/resume, full, overrun, stop and reset.
module tb_aud_recorder;

    localparam int AW = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0, pause = 1'b0, stop = 1'b0;
    logic          bclk = 1'b0, lrck = 1'b1, dat = 1'b0;
    logic [AW-1:0] addr_max = 20'd100;
    logic [15:0]   data;
    logic [AW-1:0] address;
    logic          valid;
    logic          ready = 1'b1;
    logic          busy, paused, full;
    logic [AW-1:0] end_addr;
    logic [7:0]    drop_cnt;

    int errors = 0;
    int checks = 0;

    logic [15:0]   wr_data[$];
    logic [AW-1:0] wr_addr[$];

`ifdef AUD_RECORDER_DROP_CNT_EN
    localparam logic [31:0] EXP_DROP = 32'd1;
`else
    localparam logic [31:0] EXP_DROP = 32'd0;
`endif

    aud_recorder #(.SYNC_STAGES(2), .ADDR_W(AW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_start(start), .i_pause(pause), .i_stop(stop),
        .i_AUD_BCLK(bclk), .i_AUD_ADCLRCK(lrck), .i_AUD_ADCDAT(dat),
        .i_addr_max(addr_max),
        .o_data(data), .o_address(address), .o_valid(valid), .i_ready(ready),
        .o_busy(busy), .o_paused(paused), .o_full(full),
        .o_end_addr(end_addr), .o_drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Record every accepted write, sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst && valid && ready) begin
            wr_data.push_back(data);
            wr_addr.push_back(address);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bclk_cycle(input logic lr, input logic d);
        bclk = 1'b0;
        lrck = lr;
        dat  = d;
        cycles(4);
        bclk = 1'b1;
        cycles(4);
    endtask

    // One I2S frame: 18 BCLK slots per channel, left word after one delay slot.
    task automatic send_frame(input logic [15:0] left, input logic [15:0] right);
        bclk_cycle(1'b0, 1'b0);
        for (int i = 15; i >= 0; i--) bclk_cycle(1'b0, left[i]);
        bclk_cycle(1'b0, 1'b0);
        bclk_cycle(1'b1, 1'b0);
        for (int i = 15; i >= 0; i--) bclk_cycle(1'b1, right[i]);
        bclk_cycle(1'b1, 1'b0);
        bclk = 1'b0;
        cycles(6);
    endtask

    task automatic pulse_start();
        start = 1'b1; cycles(1); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; cycles(1); stop = 1'b0;
    endtask

    task automatic restart();
        pulse_stop();
        cycles(2);
        wr_data.delete();
        wr_addr.delete();
        pulse_start();
    endtask

    initial begin
        // Reset state
        cycles(3);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_data", {16'd0, data}, 32'd0);
        rst = 1'b0;
        cycles(2);
        check("idle_addr", {12'd0, address}, 32'd0);

        // Basic capture: left word written at 0, right ignored
        pulse_start();
        check("start_busy", {31'd0, busy}, 32'd1);
        send_frame(16'hA5C3, 16'h5A5A);
        check("basic_nw", wr_data.size(), 32'd1);
        check("basic_data", {16'd0, wr_data[0]}, 32'h0000A5C3);
        check("basic_addr", {12'd0, wr_addr[0]}, 32'd0);

        // Address sequence
        restart();
        send_frame(16'h0001, 16'hFFFF);
        check("seq_busy1", {31'd0, busy}, 32'd1);
        send_frame(16'h0002, 16'hFFFF);
        send_frame(16'h0003, 16'hFFFF);
        check("seq_busy3", {31'd0, busy}, 32'd1);
        check("seq_nw", wr_data.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check("seq_data", {16'd0, wr_data[i]}, i + 1);
            check("seq_addr", {12'd0, wr_addr[i]}, i);
        end

        // Full stop at addr_max = 1
        addr_max = 20'd1;
        restart();
        send_frame(16'h1010, 16'h0000);
        send_frame(16'h2020, 16'h0000);
        send_frame(16'h3030, 16'h0000);
        check("full_nw", wr_data.size(), 32'd2);
        check("full_addr1", {12'd0, wr_addr[1]}, 32'd1);
        check("full_data1", {16'd0, wr_data[1]}, 32'h00002020);
        check("full_flag", {31'd0, full}, 32'd1);
        check("full_end", {12'd0, end_addr}, 32'd1);
        check("full_busy", {31'd0, busy}, 32'd0);

        // Overrun with ready low
        addr_max = 20'd100;
        restart();
        check("start_clr_full", {31'd0, full}, 32'd0);
        ready = 1'b0;
        send_frame(16'h1111, 16'h0000);
        send_frame(16'h2222, 16'h0000);
        check("ovr_valid", {31'd0, valid}, 32'd1);
        check("ovr_data", {16'd0, data}, 32'h00001111);
        check("ovr_drop", {24'd0, drop_cnt}, EXP_DROP);
        check("ovr_nw0", wr_data.size(), 32'd0);
        ready = 1'b1;
        cycles(3);
        check("ovr_nw1", wr_data.size(), 32'd1);
        check("ovr_wdata", {16'd0, wr_data[0]}, 32'h00001111);
        check("ovr_valid_low", {31'd0, valid}, 32'd0);

        // Pause mid-word, then resume
        restart();
        fork
            send_frame(16'h1234, 16'h0000);
            begin
                cycles(60);
                pause = 1'b1; cycles(1); pause = 1'b0;
            end
        join
        check("pause_nw", wr_data.size(), 32'd1);
        check("pause_data", {16'd0, wr_data[0]}, 32'h00001234);
        check("pause_flag", {31'd0, paused}, 32'd1);
        check("pause_busy", {31'd0, busy}, 32'd1);
        send_frame(16'h5555, 16'h0000);
        check("paused_nw", wr_data.size(), 32'd1);
        pulse_start();
        check("resume_flag", {31'd0, paused}, 32'd0);
        send_frame(16'h6789, 16'h0000);
        check("resume_nw", wr_data.size(), 32'd2);
        check("resume_data", {16'd0, wr_data[1]}, 32'h00006789);
        check("resume_addr", {12'd0, wr_addr[1]}, 32'd1);

        // Stop and start together with a pending word
        ready = 1'b0;
        send_frame(16'hAAAA, 16'h0000);
        check("pend_valid", {31'd0, valid}, 32'd1);
        stop = 1'b1; start = 1'b1;
        cycles(1);
        stop = 1'b0; start = 1'b0;
        check("ss_busy", {31'd0, busy}, 32'd0);
        check("ss_valid", {31'd0, valid}, 32'd0);
        check("ss_end", {12'd0, end_addr}, 32'd1);
        ready = 1'b1;
        cycles(3);
        check("ss_nw", wr_data.size(), 32'd2);

        // Reset during SHIFT
        wr_data.delete();
        wr_addr.delete();
        pulse_start();
        fork
            send_frame(16'hBEEF, 16'h0000);
            begin
                cycles(60);
                rst = 1'b1; cycles(1); rst = 1'b0;
                check("rstsh_busy", {31'd0, busy}, 32'd0);
                check("rstsh_valid", {31'd0, valid}, 32'd0);
                check("rstsh_data", {16'd0, data}, 32'd0);
                check("rstsh_end", {12'd0, end_addr}, 32'd0);
                check("rstsh_addr", {12'd0, address}, 32'd0);
            end
        join
        check("rstsh_nw", wr_data.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
